// File: rtl/viterbi_frame_sched.sv
// Round-robin frame scheduler sharing one Viterbi decoder between R requesters.
// Grants a whole frame, streams it into the decoder, then returns the tagged path.
module viterbi_frame_sched #(
  parameter int unsigned N   = 8,
  parameter int unsigned I   = 3,
  parameter int unsigned K   = 3,
  parameter int unsigned R   = 2,
  parameter int unsigned TMO = 255,
  localparam int unsigned SW = $clog2(I),
  localparam int unsigned OW = $clog2(K),
  localparam int unsigned IW = $clog2(R),
  localparam int unsigned LW = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [R-1:0]      req_valid_i,
  output logic [R-1:0]      req_ready_o,
  input  logic [R*LW-1:0]   req_len_i,
  input  logic [R*N*OW-1:0] req_obs_i,
  output logic              dec_start_o,
  output logic [LW-1:0]     dec_length_o,
  output logic [OW-1:0]     dec_obs_o,
  output logic              dec_obs_valid_o,
  input  logic              dec_done_i,
  input  logic [N*SW-1:0]   dec_path_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [IW-1:0]     res_id_o,
  output logic [LW-1:0]     res_len_o,
  output logic [N*SW-1:0]   res_path_o,
  output logic              res_err_o,
  output logic              busy_o
);

  localparam int unsigned TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StWait, StOut} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [LW-1:0]     len_q, len_d;
  logic [N*OW-1:0]   frame_q, frame_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              dec_start_q, dec_start_d;
  logic [LW-1:0]     dec_len_q, dec_len_d;
  logic [OW-1:0]     dec_obs_q, dec_obs_d;
  logic              dec_vld_q, dec_vld_d;
  logic [N*SW-1:0]   res_path_q, res_path_d;
  logic              res_err_q, res_err_d;
  logic [LW-1:0]     res_len_q, res_len_d;

  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  logic [LW-1:0]     gnt_len;
  logic              transfer;

  // Scan rr_q, rr_q+1, ... mod R and take the first valid requester.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = (32'(rr_q) + k) % R;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

  assign transfer = (state_q == StIdle) && gnt_found;
  assign gnt_len  = req_len_i[32'(gnt_idx)*LW +: LW];

  // Held low during reset so every output reads zero while rst_ni is asserted.
  always_comb begin
    req_ready_o = '0;
    if (transfer && rst_ni) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    len_d       = len_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    dec_start_d = 1'b0;
    dec_len_d   = dec_len_q;
    dec_obs_d   = dec_obs_q;
    dec_vld_d   = dec_vld_q;
    res_path_d  = res_path_q;
    res_err_d   = res_err_q;
    res_len_d   = res_len_q;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          id_d    = gnt_idx;
          rr_d    = (32'(gnt_idx) == R - 1) ? '0 : gnt_idx + 1'b1;
          len_d   = gnt_len;
          frame_d = req_obs_i[32'(gnt_idx)*N*OW +: N*OW];
          cnt_d   = LW'(1);
          tmr_d   = '0;
          if (gnt_len != '0) begin
            // Symbol 0 goes out alongside the start pulse.
            state_d     = StFeed;
            dec_start_d = 1'b1;
            dec_vld_d   = 1'b1;
            dec_len_d   = gnt_len;
            dec_obs_d   = req_obs_i[32'(gnt_idx)*N*OW +: OW];
          end else begin
            state_d    = StOut;
            res_err_d  = 1'b1;
            res_path_d = '0;
            res_len_d  = '0;
          end
        end
      end
      StFeed: begin
        if (cnt_q == len_q) begin
          state_d   = StWait;
          dec_vld_d = 1'b0;
          tmr_d     = '0;
        end else begin
          dec_obs_d = frame_q[32'(cnt_q)*OW +: OW];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (dec_done_i) begin
          state_d    = StOut;
          res_path_d = dec_path_i;
          res_err_d  = 1'b0;
          res_len_d  = len_q;
        end else if (tmr_q == TW'(TMO - 1)) begin
          state_d    = StOut;
          res_path_d = '0;
          res_err_d  = 1'b1;
          res_len_d  = len_q;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StOut: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      id_q        <= '0;
      len_q       <= '0;
      frame_q     <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      dec_start_q <= 1'b0;
      dec_len_q   <= '0;
      dec_obs_q   <= '0;
      dec_vld_q   <= 1'b0;
      res_path_q  <= '0;
      res_err_q   <= 1'b0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      dec_start_q <= dec_start_d;
      dec_len_q   <= dec_len_d;
      dec_obs_q   <= dec_obs_d;
      dec_vld_q   <= dec_vld_d;
      res_path_q  <= res_path_d;
      res_err_q   <= res_err_d;
      res_len_q   <= res_len_d;
    end
  end

  assign dec_start_o     = dec_start_q;
  assign dec_length_o    = dec_len_q;
  assign dec_obs_o       = dec_obs_q;
  assign dec_obs_valid_o = dec_vld_q;
  assign res_valid_o     = (state_q == StOut);
  assign res_id_o        = id_q;
  assign res_len_o       = res_len_q;
  assign res_path_o      = res_path_q;
  assign res_err_o       = res_err_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_viterbi_frame_sched.sv
// Scoreboard bench for viterbi_frame_sched with a small echoing decoder model.
module tb_viterbi_frame_sched;

  localparam int unsigned N = 8, I = 3, K = 3, R = 2, TMO = 16;
  localparam int unsigned SW = 2, OW = 2, IW = 1, LW = 3;

  logic              clk, rst_n;
  logic [R-1:0]      req_valid, req_ready;
  logic [R*LW-1:0]   req_len;
  logic [R*N*OW-1:0] req_obs;
  logic              dec_start, dec_obs_valid, dec_done;
  logic [LW-1:0]     dec_length;
  logic [OW-1:0]     dec_obs;
  logic [N*SW-1:0]   dec_path;
  logic              res_valid, res_ready, res_err, busy;
  logic [IW-1:0]     res_id;
  logic [LW-1:0]     res_len;
  logic [N*SW-1:0]   res_path;

  viterbi_frame_sched #(.N(N), .I(I), .K(K), .R(R), .TMO(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_len_i(req_len), .req_obs_i(req_obs),
    .dec_start_o(dec_start), .dec_length_o(dec_length), .dec_obs_o(dec_obs),
    .dec_obs_valid_o(dec_obs_valid), .dec_done_i(dec_done), .dec_path_i(dec_path),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
    .res_len_o(res_len), .res_path_o(res_path), .res_err_o(res_err), .busy_o(busy)
  );

  typedef struct packed {logic start; logic [LW-1:0] len; logic [OW-1:0] obs;} obs_t;
  typedef struct packed {logic [IW-1:0] id; logic [LW-1:0] len; logic [N*SW-1:0] path;
                         logic err;} res_t;

  obs_t exp_obs[$];
  res_t exp_res[$];
  int   gnt_log[$];
  int   n_vec = 0, n_fail = 0, cyc = 0;
  bit   dec_en = 1;

  localparam logic [15:0] ObsA = 16'h0250;  // 0,0,1,1,2
  localparam logic [15:0] ObsB = 16'h0006;  // 2,1,0
  localparam logic [15:0] ObsT = 16'h0009;  // 1,2

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input int g, input int len, input logic [15:0] obs,
                            input int nobs, input bit with_res, input logic [15:0] path,
                            input logic err);
    obs_t o;
    res_t r;
    for (int i = 0; i < nobs; i++) begin
      o.start = (i == 0);
      o.len   = LW'(len);
      o.obs   = obs[i*OW +: OW];
      exp_obs.push_back(o);
    end
    if (with_res) begin
      r.id = IW'(g); r.len = LW'(len); r.path = path; r.err = err;
      exp_res.push_back(r);
    end
  endtask

  task automatic set_req(input int g, input int len, input logic [15:0] obs);
    req_len[g*LW +: LW]         = LW'(len);
    req_obs[g*N*OW +: N*OW]     = obs;
  endtask

  // Returns just after the grant edge, i.e. inside the first post-grant cycle.
  task automatic send(input int g, input int len, input logic [15:0] obs);
    bit ok = 0;
    @(posedge clk); #1;
    set_req(g, len, obs);
    req_valid[g] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready[g]) begin ok = 1; break; end
    end
    if (!ok) begin n_vec++; n_fail++; $display("FAIL grant_timeout: req %0d got none", g); end
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin n_vec++; n_fail++; $display("FAIL idle_timeout: busy=%b want 0", busy); end
  endtask

  // Decoder model: echoes the observations as the path, done 3 cycles after the last one.
  initial begin
    logic [OW-1:0] m_obs[N];
    int m_n, m_cd;
    m_n = 0; m_cd = 0; dec_done = 0; dec_path = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_n = 0; m_cd = 0; dec_done = 0;
      end else begin
        dec_done = 0;
        if (dec_obs_valid) begin
          if (dec_start) m_n = 0;
          m_obs[m_n] = dec_obs;
          m_n++;
          if (m_n == int'(dec_length)) m_cd = 3;
        end else if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0 && dec_en) begin
            dec_path = '0;
            for (int t = 0; t < m_n; t++) dec_path[t*SW +: SW] = m_obs[t];
            dec_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    obs_t e;
    if (dec_obs_valid) begin
      n_vec++;
      if (exp_obs.size() == 0) begin
        n_fail++;
        $display("FAIL dec_obs_extra: got obs=%0d start=%b want none", dec_obs, dec_start);
      end else begin
        e = exp_obs.pop_front();
        if ({dec_start, dec_length, dec_obs} !== e) begin
          n_fail++;
          $display("FAIL dec_obs: got start=%b len=%0d obs=%0d want start=%b len=%0d obs=%0d",
                   dec_start, dec_length, dec_obs, e.start, e.len, e.obs);
        end
      end
    end else if (dec_start) begin
      n_vec++; n_fail++;
      $display("FAIL dec_start_stray: got 1 want 0");
    end
  end

  always @(negedge clk) if (rst_n && res_valid && res_ready) begin
    res_t e;
    n_vec++;
    if (exp_res.size() == 0) begin
      n_fail++;
      $display("FAIL res_extra: got id=%0d err=%b want none", res_id, res_err);
    end else begin
      e = exp_res.pop_front();
      if ({res_id, res_len, res_path, res_err} !== e) begin
        n_fail++;
        $display("FAIL result: got id=%0d len=%0d path=%h err=%b want id=%0d len=%0d path=%h err=%b",
                 res_id, res_len, res_path, res_err, e.id, e.len, e.path, e.err);
      end
    end
  end

  always @(negedge clk) if (rst_n && |(req_valid & req_ready)) begin
    n_vec++;
    if ($countones(req_ready) != 1) begin
      n_fail++;
      $display("FAIL grant_onehot: got %b want one-hot", req_ready);
    end
    for (int g = 0; g < R; g++) if (req_ready[g]) gnt_log.push_back(g);
  end

  initial begin
    int w0, r0;
    rst_n = 0; req_valid = '0; req_len = '0; req_obs = '0; res_ready = 1;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rst_dec", {dec_start, dec_obs_valid, dec_obs, dec_length}, 0);
    chk("rst_res", {res_valid, res_err, res_path, res_id, res_len}, 0);
    chk("rst_ready", 32'(req_ready), 0);

    // Round-robin with both requesters always valid.
    push_frame(0, 5, ObsA, 5, 1, ObsA, 0);
    push_frame(1, 3, ObsB, 3, 1, ObsB, 0);
    push_frame(0, 5, ObsA, 5, 1, ObsA, 0);
    push_frame(1, 3, ObsB, 3, 1, ObsB, 0);
    gnt_log.delete();
    @(posedge clk); #1;
    set_req(0, 5, ObsA); set_req(1, 3, ObsB);
    req_valid = 2'b11;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (gnt_log.size() >= 4) break;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_count", 32'(gnt_log.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hffff_ffff, 32'(i % 2));
    wait_idle();

    // Single frame: start pulse timing.
    push_frame(0, 5, ObsA, 5, 1, ObsA, 0);
    send(0, 5, ObsA);
    chk("start_after_grant", 32'(dec_start), 1);
    @(posedge clk); #1;
    chk("start_one_cycle", 32'(dec_start), 0);
    wait_idle();

    // Result backpressure, with req1 waiting.
    res_ready = 0;
    push_frame(0, 5, ObsA, 5, 1, ObsA, 0);
    send(0, 5, ObsA);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    set_req(1, 3, ObsB);
    req_valid[1] = 1'b1;
    push_frame(1, 3, ObsB, 3, 1, ObsB, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {res_valid, res_id, res_len, res_path, res_err, req_ready},
          {8'h0, 1'b1, 1'b0, 3'd5, 16'h0250, 1'b0, 2'b00});
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();

    // Timeout: decoder never finishes.
    dec_en = 0;
    push_frame(0, 2, ObsT, 2, 1, 16'h0, 1);
    send(0, 2, ObsT);
    w0 = -1; r0 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!dec_obs_valid) begin w0 = cyc; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin r0 = cyc; break; end
    end
    chk("tmo_latency", 32'(r0 - w0), 16);
    wait_idle();
    dec_en = 1;

    // Zero-length frame.
    push_frame(1, 0, 16'h0, 0, 1, 16'h0, 1);
    send(1, 0, 16'h0);
    chk("zl_res_next_cycle", 32'(res_valid), 1);
    wait_idle();

    // Asynchronous reset in the third FEED cycle.
    push_frame(0, 5, ObsA, 2, 0, 16'h0, 0);
    send(0, 5, ObsA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("rst_async_out", {dec_start, dec_obs_valid, dec_obs, dec_length, res_valid, busy,
                          req_ready, res_err}, 0);
    @(negedge clk); rst_n = 1;
    push_frame(0, 5, ObsA, 5, 1, ObsA, 0);
    @(posedge clk); #1;
    set_req(0, 5, ObsA); set_req(1, 3, ObsB);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_first_grant", 32'(req_ready), 32'b01);
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("obs_queue_empty", 32'(exp_obs.size()), 0);
    chk("res_queue_empty", 32'(exp_res.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/viterbi_frame_sched.md
Name: viterbi_frame_sched

Overview:
- Round-robin frame scheduler that shares one `viterbi_top` decoder between R requesters.
- Accepts a whole observation frame from the granted requester and sequences the decoder: one start pulse, then one observation per cycle.
- Waits for the decoder's done, then returns the decoded state path, tagged with the requester id, over a valid/ready result port.
- Sits between the frame sources and the decoder; the decoder has no other driver.

Parameters:
- N, 8, max sequence length; sets decoder path depth.
- I, 3, number of HMM states; SW = $clog2(I).
- K, 3, number of observation symbols; OW = $clog2(K).
- R, 2, number of requesters (R >= 2); IW = $clog2(R).
- TMO, 255, max cycles in WAIT before declaring timeout.
- Derived: LW = $clog2(N).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  R  per-requester frame request.
- req_ready  out  R  one-hot grant; a frame transfers when req_valid[g] && req_ready[g].
- req_len  in  R*LW  frame length per requester; slice g is [g*LW +: LW].
- req_obs  in  R*N*OW  frame symbols; symbol f of requester g is [(g*N+f)*OW +: OW].
- dec_start  out  1  decoder start pulse.
- dec_length  out  LW  decoder length.
- dec_obs  out  OW  decoder obs_in.
- dec_obs_valid  out  1  decoder obs_valid.
- dec_done  in  1  decoder done.
- dec_path  in  N*SW  decoder path, packed; entry t is [t*SW +: SW].
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_id  out  IW  id of the requester that owns the result.
- res_len  out  LW  frame length.
- res_path  out  N*SW  decoded path.
- res_err  out  1  1 = timeout or zero-length frame; res_path is all zero.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, FEED, WAIT, OUT.
- Reset (asynchronous, also mid-operation):
  - state = IDLE, rr_ptr = 0.
  - All outputs and counters are 0.
  - Any in-flight frame is discarded with no result.
- IDLE, grant rules:
  - req_ready is combinational.
  - Grant goes to the first g with req_valid[g] = 1, scanning rr_ptr, rr_ptr+1, ... mod R.
  - At most one bit of req_ready is set; req_ready is all zero outside IDLE.
- IDLE, on transfer:
  - Latch len, the N symbols, and id = g.
  - rr_ptr <= (g+1) mod R.
  - len != 0: go to FEED.
  - len == 0: go to OUT with res_err = 1, res_path = 0, res_len = 0.
- FEED (dec_* outputs are registered):
  - Runs exactly len cycles, using frame counter f = 0..len-1.
  - Every FEED cycle: dec_obs = symbol[f], dec_obs_valid = 1, dec_length = len.
  - First FEED cycle only: dec_start = 1. Symbol[0] is therefore presented in the same cycle as start.
  - dec_start is high in the first FEED cycle, one cycle after the grant edge.
  - After cycle len-1, go to WAIT.
  - dec_done seen during FEED is ignored.
- WAIT:
  - dec_start = 0, dec_obs_valid = 0. dec_obs and dec_length hold their values.
  - A cycle counter starts at 0.
  - If dec_done = 1: capture dec_path into res_path, res_err = 0, go to OUT.
  - Else if the counter == TMO-1: res_err = 1, res_path = 0, go to OUT.
  - dec_done takes priority over timeout when both occur in the same cycle.
- OUT:
  - res_valid = 1. res_id, res_len, res_path and res_err stay stable while res_valid && !res_ready.
  - On res_ready: res_valid <= 0, go to IDLE.
  - No grant is issued in OUT, so a new grant happens at the earliest one cycle after the result handshake.
- Throughput: one frame in flight at a time.
  - Minimum cycles from grant to res_valid = 1 + len + (decoder latency to done).
- Requesters must hold req_len and req_obs stable while req_valid is high. Values are sampled only at the transfer edge.
- len values above the LW range cannot occur (port width). len == N is unrepresentable; max frame length is 2^LW - 1.

Test Plan:
- Single frame, basic sequencing:
  - Stimulus: req0, len = 5, obs = 0,0,1,1,2. Decoder model raises done 3 cycles after the last obs, with path 0,0,1,1,2.
  - Required: dec_start high for exactly 1 cycle, one cycle after the grant. dec_obs_valid high for 5 cycles carrying 0,0,1,1,2. res_valid with res_id = 0, res_len = 5, res_path = 0,0,1,1,2, res_err = 0.
- Round-robin fairness:
  - Stimulus: req0 and req1 both held valid for 4 frames, res_ready tied to 1.
  - Required: grant order 0,1,0,1. res_id sequence is 0,1,0,1.
- Result backpressure:
  - Stimulus: res_ready low for 10 cycles after res_valid rises.
  - Required: res_valid and all res_* held stable; req_ready stays 0. The next grant occurs 1 cycle after res_ready rises.
- Timeout:
  - Stimulus: TMO = 16, decoder never asserts done.
  - Required: res_valid exactly 16 cycles after entering WAIT, with res_err = 1 and res_path = 0.
- Zero length:
  - Stimulus: req1 with len = 0.
  - Required: no dec_start and no dec_obs_valid. res_valid on the next cycle with res_id = 1, res_err = 1.
- Reset mid-frame:
  - Stimulus: assert rst_n = 0 during the 3rd FEED cycle.
  - Required: all outputs drop to 0 immediately, with no clock edge needed. After release, state is IDLE and rr_ptr = 0; with both requesters valid, the first grant goes to req0.
